// File: rtl/fetch_pc.sv
// Fetch PC and IF/ID pipeline register: next-PC selection (branch, jump, register
// jump) with a delay slot, driving instruction-memory address and decode-stage latches.
module fetch_pc #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] instr_f,
  input  logic [1:0]  npc_sel,
  input  logic        cmp_out,
  input  logic [31:0] rs_d,
  output logic [31:0] pc_f,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pc8_d,
  output logic        redirect
);

  localparam logic [1:0] NpcSeq    = 2'd0;
  localparam logic [1:0] NpcBranch = 2'd1;
  localparam logic [1:0] NpcJump   = 2'd2;
  localparam logic [1:0] NpcJreg   = 2'd3;

  logic [31:0] pc_f_q, pc_f_d;
  logic [31:0] pc_d_q, pc_d_d;
  logic [31:0] instr_d_q, instr_d_d;

  logic [31:0] pc_seq;
  logic [31:0] pc_d_plus4;
  logic [31:0] br_offset;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [31:0] npc;

  assign pc_seq     = pc_f_q + 32'd4;
  assign pc_d_plus4 = pc_d_q + 32'd4;
  // Sign-extend imm16 to 32 bits first, then scale to a word offset.
  assign br_offset  = {{14{instr_d_q[15]}}, instr_d_q[15:0], 2'b00};
  assign br_target  = pc_d_plus4 + br_offset;
  assign j_target   = {pc_d_plus4[31:28], instr_d_q[25:0], 2'b00};

  always_comb begin
    npc      = pc_seq;
    redirect = 1'b0;
    case (npc_sel)
      NpcSeq: begin
        npc      = pc_seq;
        redirect = 1'b0;
      end
      NpcBranch: begin
        if (cmp_out) begin
          npc      = br_target;
          redirect = 1'b1;
        end
      end
      NpcJump: begin
        npc      = j_target;
        redirect = 1'b1;
      end
      NpcJreg: begin
        npc      = rs_d;
        redirect = 1'b1;
      end
      default: begin
        npc      = pc_seq;
        redirect = 1'b0;
      end
    endcase
  end

  // Stall holds everything; the branch in ID stays there and is re-evaluated later.
  always_comb begin
    pc_f_d    = pc_f_q;
    pc_d_d    = pc_d_q;
    instr_d_d = instr_d_q;
    if (!stall) begin
      pc_f_d    = npc;
      pc_d_d    = pc_f_q;
      instr_d_d = instr_f;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_f_q    <= PC_RESET;
      pc_d_q    <= PC_RESET;
      instr_d_q <= 32'h0;
    end else begin
      pc_f_q    <= pc_f_d;
      pc_d_q    <= pc_d_d;
      instr_d_q <= instr_d_d;
    end
  end

  assign pc_f    = pc_f_q;
  assign pc_d    = pc_d_q;
  assign instr_d = instr_d_q;
  assign pc8_d   = pc_d_q + 32'd8;

endmodule

// File: doc/fetch_pc.md
# fetch_pc

Fetch-stage program counter plus IF/ID pipeline register for the P6 five-stage MIPS pipeline. It holds the fetch PC, drives the instruction-memory address, and latches the fetched instruction and its PC into the decode stage. It computes the next PC from the decode-stage branch comparator result (`cmp_out`), j/jal targets and jr/jalr register targets. Delay-slot semantics apply: the instruction after a branch or jump always executes and is never flushed.

## Interface
Parameters:
- `PC_RESET`, 32'h0000_3000, reset value of fetch PC and decode PC

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  1  from hazard unit; when 1, PC and IF/ID hold
- `instr_f`  in  32  instruction read combinationally from IM at `pc_f`
- `npc_sel`  in  2  from ID decode of `instr_d`: 0 sequential, 1 conditional branch, 2 j/jal, 3 jr/jalr
- `cmp_out`  in  1  branch-condition result for `instr_d` from the ID comparator
- `rs_d`  in  32  forwarded GPR[rs] value for jr/jalr
- `pc_f`  out  32  current fetch PC, to IM
- `instr_d`  out  32  IF/ID instruction register
- `pc_d`  out  32  IF/ID PC register
- `pc8_d`  out  32  `pc_d` + 8, link address for jal/jalr/bgezal-type
- `redirect`  out  1  combinational; 1 when next PC is not `pc_f` + 4

## Operation
- Next-PC selection, evaluated combinationally from decode-stage state:
  - `npc_sel`=0, or `npc_sel`=1 with `cmp_out`=0: `pc_f` + 4
  - `npc_sel`=1 with `cmp_out`=1: `pc_d` + 4 + (sign_ext(`instr_d`[15:0]) << 2)
  - `npc_sel`=2: {(`pc_d`+4)[31:28], `instr_d`[25:0], 2'b00}
  - `npc_sel`=3: `rs_d`, passed unmodified, including the low two bits
- `redirect` = 1 iff the selected next PC is not the sequential one (`npc_sel`=1 with `cmp_out`=1, or `npc_sel`=2, or `npc_sel`=3).
- Arithmetic:
  - All adds are 32-bit modulo 2^32.
  - Wrap-around is permitted and not flagged. `pc_f`=32'hFFFF_FFFC sequences to 0.
  - The branch offset is sign-extended to 32 bits before the shift.
- Per rising edge:
  - `reset`=1: `pc_f`<=`PC_RESET`, `pc_d`<=`PC_RESET`, `instr_d`<=0 (nop). `reset` overrides `stall`.
  - else `stall`=1: all registers hold. A redirect pending in ID is not lost, because `instr_d` is held and the redirect is re-evaluated once the stall drops.
  - else: `pc_f`<=next PC, `pc_d`<=`pc_f`, `instr_d`<=`instr_f`.
- Delay slot:
  - When the branch is in ID, its delay-slot instruction is in IF. That instruction is latched normally and no flush occurs.
  - A taken target therefore appears on `pc_f` exactly one cycle after the branch enters ID.
- `pc8_d` = `pc_d` + 8, combinational from the register.
- `npc_sel` and `cmp_out` are don't-care while `reset`=1.

## Timing
- Reset values: `pc_f`=32'h0000_3000, `pc_d`=32'h0000_3000, `instr_d`=0, `pc8_d`=32'h0000_3008, `redirect`=0 (since nop decodes to `npc_sel`=0).
- Register update latency:
  - `instr_f` appears on `instr_d` 1 cycle after sampling.
  - Next PC appears on `pc_f` 1 cycle after the decision.
- The branch decision is made in the same cycle the branch sits in ID. No branch prediction and no extra bubble.
- `stall` is sampled on the edge. A stall held for N cycles freezes `pc_f`, `pc_d` and `instr_d` for exactly N edges.
- Reset asserted mid-stream, including during a stall or with a taken branch in ID, takes effect at the next edge. The pending branch is discarded.
- No combinational path from `instr_f` to `pc_f`. The path from `cmp_out`/`rs_d` to next PC is combinational and is the timing-critical path.

## Test plan
- Reset and sequential: hold `reset` 2 cycles, release, IM returns nops. Required: `pc_f` = 3000, 3004, 3008 on consecutive cycles; `pc_d` lags by one; `pc8_d`=300C when `pc_d`=3004.
- Taken branch: `instr_d`=beq with imm16=16'hFFFF at `pc_d`=3010, `npc_sel`=1, `cmp_out`=1. Required:
  - `redirect`=1
  - next `pc_f`=3010 (3014−4)
  - delay slot 3014 is latched into `instr_d`
- Not-taken branch: same setup with `cmp_out`=0. Required: next `pc_f`=`pc_f`+4=3018, `redirect`=0.
- Jumps: j with imm26=26'h0000C40 at `pc_d`=3020 → next `pc_f`=3100. jr with `rs_d`=32'h0000_3abc → next `pc_f`=3abc unchanged.
- Stall with pending branch: taken branch in ID, `stall`=1 for 3 cycles. Required: `pc_f`, `pc_d` and `instr_d` frozen for 3 cycles; the target is loaded on the first unstalled edge.
- Reset mid-branch and wrap:
  - Taken branch in ID with `reset`=1. Required: `pc_f`=3000, `instr_d`=0.
  - Force `pc_f`=FFFF_FFFC via a jr, sequential step. Required: `pc_f`=0000_0000.
